cpu_sram_arbiter: RTL and testbench
===================================

Name: cpu_sram_arbiter

Overview:
- Shares one downstream SRAM-like master port (into the SRAM-to-AXI bridge) between the instruction-fetch and data-memory SRAM-like requesters.
- Issues one transaction at a time and routes its response back to the requester that owns it.
- Generates `stallreq_from_if` and `stallreq_from_mem`, which the hazard unit consumes to freeze the pipeline.
- Sits in `mycpu_top`, between the CPU core and the bridge.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants made while inst is waiting, after which inst wins the next arbitration.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; one clock, reset asynchronous and active-low.
- inst_req  in  1  fetch request, read only.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  32  fetch data.
- data_req  in  1  load/store request.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  load/store address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  load/store request accepted.
- data_data_ok  out  1  load data valid, or store completed.
- data_rdata  out  32  load data.
- m_req  out  1  downstream request.
- m_wr  out  1  downstream write.
- m_size  out  2  downstream size.
- m_addr  out  32  downstream address.
- m_wdata  out  32  downstream write data.
- m_addr_ok  in  1  downstream accept.
- m_data_ok  in  1  downstream response.
- m_rdata  in  32  downstream read data.
- stallreq_from_if  out  1  fetch stall request to the hazard unit.
- stallreq_from_mem  out  1  memory stall request to the hazard unit.

Behaviour:
- State machine has two states, IDLE and WAIT. It also keeps `owner` (INST/DATA), a starvation counter `starve_cnt` (3 bits), and flags `inst_out` and `data_out`.
- Reset, asynchronous on `aresetn` low:
  - state = IDLE, owner = INST, starve_cnt = 0, inst_out = data_out = 0.
  - All outputs 0.
  - A transaction in flight at reset is abandoned; the bridge is reset by the same signal.
- Grant, combinational, IDLE only:
  - If both requesters are active, data wins unless starve_cnt == STARVE_LIMIT, in which case inst wins.
  - A single active requester wins.
- IDLE:
  - `m_req` = req of the granted side.
  - `m_wr`, `m_size`, `m_addr`, `m_wdata` are muxed from the granted side.
  - Inst is always presented as wr=0, size=2, wdata=0.
  - `<side>_addr_ok` = `m_addr_ok` & granted. Only one `addr_ok` is ever high in a cycle.
- IDLE -> WAIT on `m_req` & `m_addr_ok`: register owner, set `<owner>_out`.
- starve_cnt update on each accepted grant:
  - Data grant while inst_req is high: starve_cnt +1, saturating at STARVE_LIMIT.
  - Inst grant: starve_cnt cleared.
  - Data grant with inst_req low: no change.
- WAIT:
  - `m_req` = 0. All `addr_ok` outputs = 0.
  - On `m_data_ok`: `<owner>_data_ok` = 1, `<owner>_rdata` = `m_rdata` (combinational pass-through), clear `<owner>_out`, go to IDLE.
  - The next grant happens no earlier than the following cycle. Minimum transaction: 1 cycle accept, then 1 cycle WAIT.
- Non-owner outputs: `rdata` = 0 and `data_ok` = 0.
- `m_data_ok` in IDLE is a protocol error: it is ignored and no state change occurs.
- Store response: `data_data_ok` pulses once; `data_rdata` carries no meaning.
- Stall outputs (combinational):
  - stallreq_from_if = (inst_req & ~inst_addr_ok) | (inst_out & ~inst_data_ok).
  - stallreq_from_mem = (data_req & ~data_addr_ok) | (data_out & ~data_data_ok).
  - Both fall in the same cycle the corresponding `data_ok` is high. This lets the pipeline capture data and advance that cycle.
- Requesters hold req, addr, and wdata stable until `addr_ok`. The arbiter does not register the request fields.
- `m_addr_ok` and `m_data_ok` in the same cycle while in IDLE: accept only. The response is taken from WAIT in a later cycle; the bridge never does this.

Decomposition:
- Shared package `cpu_defs`: the owner encoding (OWN_INST = 0, OWN_DATA = 1), the size constants (SZ_BYTE/HALF/WORD), and the state encoding (S_IDLE/S_WAIT).
- No sub-module. The grant logic is a few lines and stays inline.

Test Plan:
- Inst only: inst_req=1, addr 0xBFC00000. `m_addr_ok` in cycle 1, `m_data_ok` 3 cycles later with 0x3C1D0000. Expect:
  - inst_addr_ok in cycle 1.
  - inst_data_ok=1 with inst_rdata=0x3C1D0000.
  - stallreq_from_if high from cycle 0 until that cycle, low in it.
- Simultaneous: inst_req and data_req (load, 0x80001000) both high in cycle 0, bridge always ready. Expect:
  - The data side is granted first; m_addr=0x80001000.
  - The inst side is granted in the cycle after data_data_ok.
  - stallreq_from_if stays high throughout.
- Starvation: inst_req held high, data_req re-asserted every IDLE cycle, STARVE_LIMIT=4. Expect:
  - 4 data grants, then 1 inst grant, then the pattern repeats.
  - starve_cnt reads 0 after the inst grant.
- Store: data_wr=1, size=0, addr 0x80000003, wdata 0xAB. Expect:
  - m_wr=1, m_size=0, m_wdata=0xAB.
  - data_data_ok pulses once.
  - inst_data_ok stays 0.
- Reset mid-transaction: aresetn low while in WAIT with owner DATA. Expect:
  - All outputs 0 immediately.
  - After release, state is IDLE and a fresh inst request is granted normally.
- Protocol error: m_data_ok pulsed in IDLE with no outstanding transaction. Expect both data_ok outputs 0 and no state change.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the CPU-side SRAM-like arbitration logic:
// requester ownership, transfer sizes and arbiter state.
package cpu_defs;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like master port between the fetch and load/store requesters,
// one transaction at a time, and raises the pipeline stall requests.
module cpu_sram_arbiter
    import cpu_defs::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        stallreq_from_if,
    output logic        stallreq_from_mem
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state_reg;
    owner_t     owner_reg;
    logic [2:0] starve_cnt_reg;
    logic       inst_out_reg;
    logic       data_out_reg;

    logic grant_data;
    logic grant_inst;
    logic accept;

    // Data wins ties unless inst has been passed over LIMIT times in a row.
    always_comb begin
        grant_data = data_req & (~inst_req | (starve_cnt_reg != LIMIT));
        grant_inst = inst_req & ~grant_data;
        accept     = (state_reg == S_IDLE) & (grant_inst | grant_data) & m_addr_ok;
    end

    // Outputs are gated by aresetn so they drop the moment reset asserts.
    always_comb begin
        m_req             = 1'b0;
        m_wr              = 1'b0;
        m_size            = SZ_BYTE;
        m_addr            = 32'd0;
        m_wdata           = 32'd0;
        inst_addr_ok      = 1'b0;
        data_addr_ok      = 1'b0;
        inst_data_ok      = 1'b0;
        inst_rdata        = 32'd0;
        data_data_ok      = 1'b0;
        data_rdata        = 32'd0;
        stallreq_from_if  = 1'b0;
        stallreq_from_mem = 1'b0;
        if (aresetn) begin
            if (state_reg == S_IDLE) begin
                m_req = grant_inst | grant_data;
                if (grant_data) begin
                    m_wr    = data_wr;
                    m_size  = data_size;
                    m_addr  = data_addr;
                    m_wdata = data_wdata;
                end else if (grant_inst) begin
                    m_size  = SZ_WORD;
                    m_addr  = inst_addr;
                end
                inst_addr_ok = grant_inst & m_addr_ok;
                data_addr_ok = grant_data & m_addr_ok;
            end else if (m_data_ok) begin
                if (owner_reg == OWN_DATA) begin
                    data_data_ok = 1'b1;
                    data_rdata   = m_rdata;
                end else begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = m_rdata;
                end
            end
            stallreq_from_if  = (inst_req & ~inst_addr_ok) | (inst_out_reg & ~inst_data_ok);
            stallreq_from_mem = (data_req & ~data_addr_ok) | (data_out_reg & ~data_data_ok);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= S_IDLE;
            owner_reg      <= OWN_INST;
            starve_cnt_reg <= 3'd0;
            inst_out_reg   <= 1'b0;
            data_out_reg   <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            // A response seen here has no owner and is dropped.
            if (accept) begin
                state_reg <= S_WAIT;
                if (grant_data) begin
                    owner_reg    <= OWN_DATA;
                    data_out_reg <= 1'b1;
                    if (inst_req && starve_cnt_reg != LIMIT)
                        starve_cnt_reg <= starve_cnt_reg + 3'd1;
                end else begin
                    owner_reg      <= OWN_INST;
                    inst_out_reg   <= 1'b1;
                    starve_cnt_reg <= 3'd0;
                end
            end
        end else if (m_data_ok) begin
            state_reg <= S_IDLE;
            if (owner_reg == OWN_DATA)
                data_out_reg <= 1'b0;
            else
                inst_out_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter: the bench plays the bridge and keeps a
// scoreboard of expected responses pushed at accept time.
module tb_cpu_sram_arbiter;
    import cpu_defs::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        stallreq_from_if, stallreq_from_mem;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        side;
        logic [31:0] rdata;
    } resp_t;
    resp_t sb_q[$];

    always #5 aclk = ~aclk;

    cpu_sram_arbiter #(.STARVE_LIMIT(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Bridge accepts this cycle; the expected winner and its future read data go to the scoreboard.
    task automatic accept(input logic side, input logic [31:0] rdata);
        resp_t e;
        m_addr_ok = 1'b1;
        #3;
        chk("m_req", m_req, 1'b1);
        chk("inst_addr_ok", inst_addr_ok, side == OWN_INST);
        chk("data_addr_ok", data_addr_ok, side == OWN_DATA);
        e.side = side;
        e.rdata = rdata;
        sb_q.push_back(e);
        $display("accept side=%0d m_addr=%h m_wr=%0d m_size=%0d", side, m_addr, m_wr, m_size);
        cyc();
        m_addr_ok = 1'b0;
        if (side == OWN_INST) inst_req = 1'b0;
        else data_req = 1'b0;
    endtask

    // Hold the transaction in WAIT for extra cycles, then deliver the scoreboard head.
    task automatic respond(input int extra);
        resp_t e;
        for (int i = 0; i < extra; i++) begin
            #3;
            chk("wait_m_req", m_req, 1'b0);
            chk("wait_inst_data_ok", inst_data_ok, 1'b0);
            chk("wait_data_data_ok", data_data_ok, 1'b0);
            if (sb_q.size() != 0 && sb_q[0].side == OWN_INST)
                chk("wait_stall_if", stallreq_from_if, 1'b1);
            else
                chk("wait_stall_mem", stallreq_from_mem, 1'b1);
            cyc();
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb_q.pop_front();
        m_data_ok = 1'b1;
        m_rdata = e.rdata;
        #3;
        chk("inst_data_ok", inst_data_ok, e.side == OWN_INST);
        chk("data_data_ok", data_data_ok, e.side == OWN_DATA);
        if (e.side == OWN_INST) begin
            chk("inst_rdata", inst_rdata, e.rdata);
            chk("data_rdata_nonowner", data_rdata, 32'd0);
            chk("stall_if_at_data_ok", stallreq_from_if, inst_req);
        end else begin
            chk("data_rdata", data_rdata, e.rdata);
            chk("inst_rdata_nonowner", inst_rdata, 32'd0);
            chk("stall_mem_at_data_ok", stallreq_from_mem, data_req);
        end
        $display("respond side=%0d rdata=%h", e.side, e.rdata);
        cyc();
        m_data_ok = 1'b0;
        m_rdata = 32'd0;
    endtask

    initial begin
        int cnt_model;
        logic exp_side;

        // Reset state
        #2;
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_stall_if", stallreq_from_if, 1'b0);
        cyc();
        aresetn = 1'b1;
        cyc();
        chk("rst_state", dut.state_reg, S_IDLE);
        chk("rst_starve", dut.starve_cnt_reg, 3'd0);

        // Inst only, accepted one cycle late, response three WAIT cycles later
        inst_req = 1'b1;
        inst_addr = 32'hBFC00000;
        #3;
        chk("if_stall_c0", stallreq_from_if, 1'b1);
        chk("if_addr_ok_c0", inst_addr_ok, 1'b0);
        chk("if_m_addr", m_addr, 32'hBFC00000);
        chk("if_m_size", m_size, SZ_WORD);
        chk("if_m_wr", m_wr, 1'b0);
        cyc();
        accept(OWN_INST, 32'h3C1D0000);
        respond(2);

        // Simultaneous: data first, inst granted right after data_data_ok
        inst_req = 1'b1;
        inst_addr = 32'hBFC00004;
        data_req = 1'b1;
        data_wr = 1'b0;
        data_size = SZ_WORD;
        data_addr = 32'h80001000;
        #1;
        chk("sim_m_addr", m_addr, 32'h80001000);
        chk("sim_stall_if", stallreq_from_if, 1'b1);
        accept(OWN_DATA, 32'h11223344);
        chk("sim_stall_if_wait", stallreq_from_if, 1'b1);
        respond(0);
        chk("sim_inst_m_addr", m_addr, 32'hBFC00004);
        accept(OWN_INST, 32'h55667788);
        respond(0);

        // Starvation: model counter decides the winner of each tie
        cnt_model = 0;
        for (int t = 0; t < 10; t++) begin
            inst_req = 1'b1;
            inst_addr = 32'hBFC00100 + 32'(t * 4);
            data_req = 1'b1;
            data_addr = 32'h80002000 + 32'(t * 4);
            exp_side = (cnt_model == 4) ? OWN_INST : OWN_DATA;
            #1;
            chk("starve_m_addr", m_addr, exp_side == OWN_INST ? inst_addr : data_addr);
            accept(exp_side, 32'hA0000000 + 32'(t));
            if (exp_side == OWN_INST) begin
                cnt_model = 0;
                chk("starve_cnt_cleared", dut.starve_cnt_reg, 3'd0);
            end else begin
                cnt_model++;
            end
            respond(0);
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        cyc();

        // Store byte
        data_req = 1'b1;
        data_wr = 1'b1;
        data_size = SZ_BYTE;
        data_addr = 32'h80000003;
        data_wdata = 32'h000000AB;
        #1;
        chk("st_m_wr", m_wr, 1'b1);
        chk("st_m_size", m_size, SZ_BYTE);
        chk("st_m_wdata", m_wdata, 32'h000000AB);
        chk("st_m_addr", m_addr, 32'h80000003);
        accept(OWN_DATA, 32'hDEADBEEF);
        respond(1);
        #3;
        chk("st_data_ok_once", data_data_ok, 1'b0);
        chk("st_inst_data_ok", inst_data_ok, 1'b0);
        cyc();
        data_wr = 1'b0;

        // Reset while a data transaction is in WAIT
        data_req = 1'b1;
        data_addr = 32'h80003000;
        accept(OWN_DATA, 32'h0);
        inst_req = 1'b1;
        inst_addr = 32'hBFC00200;
        m_data_ok = 1'b1;
        m_rdata = 32'hFFFFFFFF;
        #1;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_m_req", m_req, 1'b0);
        chk("rst_mid_data_ok", data_data_ok, 1'b0);
        chk("rst_mid_data_rdata", data_rdata, 32'd0);
        chk("rst_mid_stall_if", stallreq_from_if, 1'b0);
        chk("rst_mid_stall_mem", stallreq_from_mem, 1'b0);
        chk("rst_mid_inst_addr_ok", inst_addr_ok, 1'b0);
        sb_q.delete();
        m_data_ok = 1'b0;
        m_rdata = 32'd0;
        cyc();
        aresetn = 1'b1;
        cyc();
        chk("rst_rel_state", dut.state_reg, S_IDLE);
        chk("rst_rel_m_addr", m_addr, 32'hBFC00200);
        accept(OWN_INST, 32'h12345678);
        respond(0);

        // Protocol error: response while idle with nothing outstanding
        m_data_ok = 1'b1;
        m_rdata = 32'hCAFEF00D;
        #3;
        chk("perr_inst_data_ok", inst_data_ok, 1'b0);
        chk("perr_data_data_ok", data_data_ok, 1'b0);
        chk("perr_inst_rdata", inst_rdata, 32'd0);
        cyc();
        m_data_ok = 1'b0;
        #3;
        chk("perr_state", dut.state_reg, S_IDLE);
        cyc();
        inst_req = 1'b1;
        inst_addr = 32'hBFC00300;
        accept(OWN_INST, 32'h0BADF00D);
        respond(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
